serial_tx_framer: RTL

- Transmit-side framing stage of the serial communication path.
- Accepts a parallel character, serialises it as start bit, LSB-first data bits, then stop bit.
- Generates the bit-sample count (bsc) and bit index that the downstream bit-index/char-sent logic consumes.
- Emits a one-cycle char_sent pulse when the stop bit completes.

---
 rtl/serial_tx_framer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_tx_framer.sv
// Transmit framing stage: serialises one character as a start bit, DATA_BITS
// data bits LSB first, then a stop bit. Each bit lasts SAMPLES_PER_BIT sample
// ticks, and a sample tick occurs once every CLK_DIV clocks.
//
// Ports:
//   clk_i             system clock, all state on the rising edge
//   rst_ni            asynchronous active-low reset, forces idle
//   transmit_enable_i load request, honoured only while ready_o=1
//   data_in_i         character latched on an accepted request
//   serial_out_o      registered serial line, idles high
//   ready_o / busy_o  idle indicator and its complement
//   bsc_o             sample index within the current bit
//   bit_idx_o         0=start, 1..DATA_BITS=data, DATA_BITS+1=stop
//   char_sent_o       one-cycle pulse after the stop bit completes
module serial_tx_framer #(
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned SAMPLES_PER_BIT = 16,
  parameter int unsigned CLK_DIV         = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 transmit_enable_i,
  input  logic [DATA_BITS-1:0] data_in_i,
  output logic                 serial_out_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic [3:0]           bsc_o,
  output logic [3:0]           bit_idx_o,
  output logic                 char_sent_o
);

  localparam int unsigned     DivW     = $clog2(CLK_DIV) + 1;
  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [3:0]      BscLast  = 4'(SAMPLES_PER_BIT - 1);
  localparam logic [3:0]      LastData = 4'(DATA_BITS);
  localparam logic [3:0]      StopIdx  = 4'(DATA_BITS + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [3:0]           bsc_q, bsc_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 char_sent_q, char_sent_d;
  logic                 tick;
  logic                 bit_end;

  assign tick    = (div_q == DivLast);
  assign bit_end = tick && (bsc_q == BscLast);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bsc_d       = bsc_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    serial_d    = serial_q;
    char_sent_d = 1'b0;

    // Divider and sample counter only run while a frame is in flight.
    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        bsc_d = bit_end ? 4'd0 : bsc_q + 4'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        div_d     = '0;
        bsc_d     = 4'd0;
        bit_idx_d = 4'd0;
        serial_d  = 1'b1;
        if (transmit_enable_i) begin
          state_d  = StStart;
          shift_d  = data_in_i;
          serial_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = 4'd1;
          serial_d  = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == LastData) begin
            state_d   = StStop;
            bit_idx_d = StopIdx;
            serial_d  = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 4'd1;
            // Present the next data bit in the same edge as the shift.
            serial_d  = shift_d[0];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d     = StIdle;
          bit_idx_d   = 4'd0;
          serial_d    = 1'b1;
          char_sent_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bsc_q       <= 4'd0;
      bit_idx_q   <= 4'd0;
      shift_q     <= '0;
      serial_q    <= 1'b1;
      char_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bsc_q       <= bsc_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      serial_q    <= serial_d;
      char_sent_q <= char_sent_d;
    end
  end

  assign serial_out_o = serial_q;
  assign ready_o      = (state_q == StIdle);
  assign busy_o       = ~ready_o;
  assign bsc_o        = bsc_q;
  assign bit_idx_o    = bit_idx_q;
  assign char_sent_o  = char_sent_q;

endmodule
